zld_xc9: RTL and testbench

Zero run-length decoder; the stage directly downstream of the zero run-length encoder. It consumes the encoder's 4-bit token stream and expands it back into the original 3-bit symbol stream. Both sides use valid/back-pressure stream handshakes. It is a single module with an embedded FSM, run counter and registered output slot.

---
 rtl/zld_xc9.sv | 64 ++++++
 tb/tb_zld_xc9.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/zld_xc9.sv
// zld_xc9: zero run-length token decoder with registered output slot; `ZLD_XC9_STATS_EN adds a saturating zero-symbol counter.
module zld_xc9 (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] i_d,
  input  logic       i_v,
  output logic       i_b,
  output logic [2:0] o_d,
  output logic       o_v,
  input  logic       o_b
`ifdef ZLD_XC9_STATS_EN
  ,
  output logic [15:0] zeros_out
`endif
);
  typedef enum logic {S_TOK, S_RUN} state_t;
  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt, w_d_nxt;
  logic       w_free, w_take, w_v_nxt;
  always_comb begin
    w_free      = !o_v || !o_b;
    w_take      = (r_state == S_TOK) && i_v && w_free;
    i_b         = (r_state == S_RUN) || !w_free;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_nxt     = o_d;
    w_v_nxt     = o_v;
    if (w_free) begin
      w_v_nxt = 1'b0;
      if (w_take) begin
        w_d_nxt     = i_d[3] ? 3'd0 : i_d[2:0];
        w_v_nxt     = 1'b1;
        w_cnt_nxt   = i_d[3] ? i_d[2:0] : r_cnt;
        w_state_nxt = (i_d[3] && i_d[2:0] != 3'd0) ? S_RUN : S_TOK;
      end else if (r_state == S_RUN) begin
        w_d_nxt     = 3'd0;
        w_v_nxt     = 1'b1;
        w_cnt_nxt   = r_cnt - 3'd1;
        w_state_nxt = (r_cnt == 3'd1) ? S_TOK : S_RUN;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_TOK;
      r_cnt   <= 3'd0;
      o_d     <= 3'd0;
      o_v     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      o_d     <= w_d_nxt;
      o_v     <= w_v_nxt;
    end
  end
`ifdef ZLD_XC9_STATS_EN
  always_ff @(posedge clock) begin
    if (reset)
      zeros_out <= 16'd0;
    else if (o_v && !o_b && o_d == 3'd0 && zeros_out != 16'hFFFF)
      zeros_out <= zeros_out + 16'd1;
  end
`endif
endmodule

// File: tb/tb_zld_xc9.sv
// tb_zld_xc9: directed and random checks of zld_xc9 against a queue model of the expanded symbol stream.
module tb_zld_xc9;
  logic       clock = 1'b0, reset = 1'b1;
  logic [3:0] i_d = 4'd0;
  logic       i_v = 1'b0, i_b;
  logic [2:0] o_d;
  logic       o_v, o_b = 1'b0;
  int         n_chk = 0, n_err = 0, n_out = 0, n0, t, zc = 0;
  logic [2:0] q[$];
  logic       acc, otx;
`ifdef ZLD_XC9_STATS_EN
  logic [15:0] zeros_out;
`endif

  always #5 clock = ~clock;

  zld_xc9 dut (
    .clock(clock), .reset(reset), .i_d(i_d), .i_v(i_v), .i_b(i_b),
    .o_d(o_d), .o_v(o_v), .o_b(o_b)
`ifdef ZLD_XC9_STATS_EN
    , .zeros_out(zeros_out)
`endif
  );

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue holds every symbol accepted but not yet transferred out; its head must be in the slot.
  task automatic cyc();
    @(negedge clock);
    chk(32'(o_v), 32'(q.size() != 0), "o_v");
    if (q.size() != 0) chk(32'(o_d), 32'(q[0]), "o_d");
    chk(32'(i_b), 32'(q.size() > 1 || (q.size() == 1 && o_b)), "i_b");
`ifdef ZLD_XC9_STATS_EN
    chk(32'(zeros_out), zc, "zeros_out");
`endif
    acc = i_v && !i_b;
    otx = o_v && !o_b;
    if (reset) begin
      q.delete();
      zc = 0;
    end else begin
      if (otx) begin
        n_out++;
        if (q[0] == 3'd0 && zc < 65535) zc++;
        void'(q.pop_front());
      end
      if (acc) begin
        if (i_d[3]) repeat (int'(i_d[2:0]) + 1) q.push_back(3'd0);
        else q.push_back(i_d[2:0]);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] tok, output int tries);
    i_d = tok;
    i_v = 1'b1;
    tries = 0;
    do begin
      cyc();
      tries++;
    end while (!acc && tries < 32);
    chk(32'(acc), 1, "accept_timeout");
    i_v = 1'b0;
    i_d = 4'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 64) begin
      cyc();
      k++;
    end
    chk(32'(q.size() == 0), 1, "drain_timeout");
    cyc();
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk(32'(o_v), 0, "rst_o_v");
    chk(32'(o_d), 0, "rst_o_d");
    chk(32'(i_b), 0, "rst_i_b");
    send(4'h3, t); chk(t, 1, "lit3_tries");
    send(4'h7, t); chk(t, 1, "lit7_tries");
    send(4'h0, t); chk(t, 1, "lit0_tries");
    drain();
    n0 = n_out;
    send(4'hF, t);
    send(4'h5, t); chk(t, 8, "run8_next_tries");
    drain();
    chk(n_out - n0, 9, "run8_count");
    n0 = n_out;
    send(4'h8, t);
    send(4'h1, t); chk(t, 1, "run1_next_tries");
    drain();
    chk(n_out - n0, 2, "run1_count");
    n0 = n_out;
    send(4'hB, t);
    cyc();
    cyc();
    o_b = 1'b1;
    repeat (3) cyc();
    o_b = 1'b0;
    drain();
    chk(n_out - n0, 4, "bp_run_count");
    send(4'hF, t);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk(32'(o_v), 0, "rst_mid_o_v");
    chk(32'(i_b), 0, "rst_mid_i_b");
    n0 = n_out;
    send(4'h2, t);
    drain();
    chk(n_out - n0, 1, "rst_mid_count");
`ifdef ZLD_XC9_STATS_EN
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    send(4'h0, t);
    send(4'hC, t);
    send(4'h1, t);
    drain();
    chk(32'(zeros_out), 6, "stats_six");
    repeat (8200) send(4'hF, t);
    drain();
    chk(32'(zeros_out), 32'hFFFF, "stats_sat");
`endif
    repeat (400) begin
      i_v = 1'($urandom_range(0, 1));
      i_d = 4'($urandom);
      o_b = ($urandom_range(0, 9) < 3);
      cyc();
    end
    i_v = 1'b0;
    o_b = 1'b0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
